// File: rtl/clk_mon_pkg.sv
// Shared types for the divided-clock monitor: FSM states and fault codes.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACQ   = 2'd1,
        LOCK  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_TIMEOUT = 2'b01;
    localparam logic [1:0] FC_PERIOD  = 2'b10;
    localparam logic [1:0] FC_DUTY    = 2'b11;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser plus delay flop with registered rise/fall pulses.
// 'level' is aligned with the pulses: it is high in the cycle rise is high.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s0, s1, s1_d;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0   <= 1'b0;
            s1   <= 1'b0;
            s1_d <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s0   <= d;
            s1   <= s0;
            s1_d <= s1;
            rise <= s1 & ~s1_d;
            fall <= ~s1 & s1_d;
        end
    end

    assign level = s1_d;

endmodule

// File: rtl/div_clk_monitor.sv
// Measures period and high time of a divided clock and tracks lock/fault.
module div_clk_monitor
    import clk_mon_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int EXP_PERIOD = 8,
    parameter int PER_TOL    = 0,
    parameter int DUTY_TOL   = 0,
    parameter int LOCK_CNT   = 4,
    parameter int MAX_PERIOD = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_clk_in,
    input  logic             clr_fault,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             locked,
    output logic             fault,
    output logic [1:0]       fault_code
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] MAXP     = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W:0]   EXP_W    = (CNT_W+1)'(EXP_PERIOD);
    localparam logic [CNT_W:0]   PTOL_W   = (CNT_W+1)'(PER_TOL);
    localparam logic [CNT_W:0]   DTOL_W   = (CNT_W+1)'(DUTY_TOL);

    logic             lvl, rise, fall;
    logic [CNT_W-1:0] cnt, hcnt, hi_cap;
    logic [GW-1:0]    good_cnt, good_nxt;
    state_t           state, state_nxt;
    logic [1:0]       code_nxt;
    logic             capture, clear;
    logic [CNT_W:0]   cnt_w, two_hi, per_diff, duty_diff;
    logic             per_ok, duty_ok, timeout;

    sync_edge_det u_sync (
        .clk   (clk),
        .rst   (rst),
        .d     (div_clk_in),
        .level (lvl),
        .rise  (rise),
        .fall  (fall)
    );

    // Widened by one bit so 2*hi_cap and the differences cannot wrap.
    assign cnt_w     = {1'b0, cnt};
    assign two_hi    = {hi_cap, 1'b0};
    assign per_diff  = (cnt_w >= EXP_W) ? cnt_w - EXP_W : EXP_W - cnt_w;
    assign duty_diff = (two_hi >= cnt_w) ? two_hi - cnt_w : cnt_w - two_hi;
    assign per_ok    = (per_diff <= PTOL_W);
    assign duty_ok   = (duty_diff <= DTOL_W);
    assign timeout   = (cnt == MAXP);

    // NOTE: every output of this block gets a default first, so no latches.
    always_comb begin
        state_nxt = state;
        code_nxt  = fault_code;
        good_nxt  = good_cnt;
        capture   = 1'b0;
        clear     = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = ACQ;
                    good_nxt  = '0;
                end else if (timeout) begin
                    state_nxt = FAULT;
                    code_nxt  = FC_TIMEOUT;
                end
            end
            ACQ: begin
                if (rise) begin
                    capture = 1'b1;
                    if (per_ok && duty_ok) begin
                        if (good_cnt == GW'(LOCK_CNT - 1)) begin
                            state_nxt = LOCK;
                            good_nxt  = GW'(LOCK_CNT);
                        end else begin
                            good_nxt = good_cnt + 1'b1;
                        end
                    end else begin
                        good_nxt = '0;
                    end
                end else if (timeout) begin
                    state_nxt = FAULT;
                    code_nxt  = FC_TIMEOUT;
                end
            end
            LOCK: begin
                if (rise) begin
                    capture = 1'b1;
                    if (!per_ok) begin
                        state_nxt = FAULT;
                        code_nxt  = FC_PERIOD;
                    end else if (!duty_ok) begin
                        state_nxt = FAULT;
                        code_nxt  = FC_DUTY;
                    end
                end else if (timeout) begin
                    state_nxt = FAULT;
                    code_nxt  = FC_TIMEOUT;
                end
            end
            FAULT: begin
                if (clr_fault) begin
                    state_nxt = IDLE;
                    code_nxt  = FC_NONE;
                    clear     = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            fault_code <= FC_NONE;
            good_cnt   <= '0;
            locked     <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state      <= state_nxt;
            fault_code <= code_nxt;
            good_cnt   <= good_nxt;
            locked     <= (state_nxt == LOCK);
            fault      <= (state_nxt == FAULT);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            hcnt   <= '0;
            hi_cap <= '0;
        end else begin
            if (clear)
                cnt <= '0;
            else if (rise)
                cnt <= CNT_W'(1);
            else if (cnt != MAXP)
                cnt <= cnt + 1'b1;

            if (rise)
                hcnt <= CNT_W'(1);
            else if (lvl && hcnt != MAXP)
                hcnt <= hcnt + 1'b1;

            if (fall)
                hi_cap <= hcnt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= capture;
            if (capture) begin
                period    <= cnt;
                high_time <= hi_cap;
            end
        end
    end

endmodule

// File: tb/tb_div_clk_monitor.sv
// Directed self-checking bench for div_clk_monitor.
module tb_div_clk_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_clk_in;
    logic        clr_fault;
    logic [15:0] period;
    logic [15:0] high_time;
    logic        period_valid;
    logic        locked;
    logic        fault;
    logic [1:0]  fault_code;

    int n_checks = 0;
    int n_fail   = 0;
    int vcount   = 0;
    int lock_vc  = 0;
    int vc_hold  = 0;
    logic [15:0] pv_per  = '0;
    logic [15:0] pv_high = '0;

    always #5 clk = ~clk;

    div_clk_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .div_clk_in   (div_clk_in),
        .clr_fault    (clr_fault),
        .period       (period),
        .high_time    (high_time),
        .period_valid (period_valid),
        .locked       (locked),
        .fault        (fault),
        .fault_code   (fault_code)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clk cycle: sample outputs at the falling edge, then drive inputs.
    task automatic cyc(input logic v, input logic c);
        @(negedge clk);
        if (period_valid === 1'b1) begin
            vcount++;
            pv_per  = period;
            pv_high = high_time;
        end
        if (locked === 1'b1 && lock_vc == 0)
            lock_vc = vcount;
        div_clk_in = v;
        clr_fault  = c;
    endtask

    task automatic wave(input int h, input int l);
        repeat (h) cyc(1'b1, 1'b0);
        repeat (l) cyc(1'b0, 1'b0);
    endtask

    task automatic clear_fault();
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        check("clr_fault", {31'd0, fault}, 32'd0);
        check("clr_code", {30'd0, fault_code}, 32'd0);
    endtask

    task automatic relock();
        repeat (5) wave(4, 4);
        check("relock", {31'd0, locked}, 32'd1);
    endtask

    initial begin
        rst        = 1'b0;
        div_clk_in = 1'b0;
        clr_fault  = 1'b0;
        #3;
        check("rst_period", {16'd0, period}, 32'd0);
        check("rst_high", {16'd0, high_time}, 32'd0);
        check("rst_pv", {31'd0, period_valid}, 32'd0);
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_code", {30'd0, fault_code}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Nominal 4/4 waveform: IDLE rise, then four good periods to lock.
        wave(4, 4);
        check("idle_no_pv", vcount, 32'd0);
        repeat (4) cyc(1'b1, 1'b0);
        check("latency_early", {31'd0, period_valid}, 32'd0);
        cyc(1'b0, 1'b0);
        check("latency_pv", {31'd0, period_valid}, 32'd1);
        repeat (3) cyc(1'b0, 1'b0);
        check("first_period", {16'd0, pv_per}, 32'd8);
        check("first_high", {16'd0, pv_high}, 32'd4);
        wave(4, 4);
        wave(4, 4);
        check("acq_unlocked", {31'd0, locked}, 32'd0);
        wave(4, 4);
        check("lock_on_4th", lock_vc, 32'd4);
        check("lock_vcount", vcount, 32'd4);
        check("lock_period", {16'd0, pv_per}, 32'd8);
        check("lock_high", {16'd0, pv_high}, 32'd4);
        check("lock_code", {30'd0, fault_code}, 32'd0);

        // Timeout: hold low after the last rise.
        repeat (60) cyc(1'b0, 1'b0);
        check("timeout_early", {31'd0, fault}, 32'd0);
        cyc(1'b0, 1'b0);
        check("timeout_fault", {31'd0, fault}, 32'd1);
        check("timeout_code", {30'd0, fault_code}, 32'd1);
        check("timeout_unlock", {31'd0, locked}, 32'd0);
        clear_fault();

        // Acquisition with one bad 10-cycle period: 8,8,10,8,8,8,8.
        vcount  = 0;
        lock_vc = 0;
        wave(4, 4);
        wave(4, 4);
        wave(5, 5);
        wave(4, 4);
        check("acq_bad_period", {16'd0, pv_per}, 32'd10);
        check("acq_no_fault", {31'd0, fault}, 32'd0);
        wave(4, 4);
        wave(4, 4);
        wave(4, 4);
        check("acq_still_unlocked", {31'd0, locked}, 32'd0);
        wave(4, 4);
        check("acq_lock_on_7th", lock_vc, 32'd7);
        check("acq_locked", {31'd0, locked}, 32'd1);

        // Period fault while locked.
        wave(5, 5);
        wave(4, 4);
        check("per_fault", {31'd0, fault}, 32'd1);
        check("per_code", {30'd0, fault_code}, 32'd2);
        check("per_value", {16'd0, period}, 32'd10);
        check("per_unlock", {31'd0, locked}, 32'd0);
        clear_fault();
        relock();

        // Duty fault while locked, then FAULT is sticky with no captures.
        wave(3, 5);
        wave(4, 4);
        check("duty_code", {30'd0, fault_code}, 32'd3);
        check("duty_high", {16'd0, high_time}, 32'd3);
        check("duty_period", {16'd0, period}, 32'd8);
        vc_hold = vcount;
        wave(4, 4);
        wave(4, 4);
        check("sticky_no_pv", vcount, vc_hold);
        check("sticky_code", {30'd0, fault_code}, 32'd3);
        clear_fault();
        relock();

        // Asynchronous reset mid-lock, then two rises before a capture.
        #2 rst = 1'b0;
        #1;
        check("arst_locked", {31'd0, locked}, 32'd0);
        check("arst_period", {16'd0, period}, 32'd0);
        check("arst_high", {16'd0, high_time}, 32'd0);
        @(negedge clk);
        rst    = 1'b1;
        vcount = 0;
        wave(4, 4);
        check("post_rst_no_pv", vcount, 32'd0);
        wave(4, 4);
        check("post_rst_pv", vcount, 32'd1);
        check("post_rst_period", {16'd0, pv_per}, 32'd8);
        check("post_rst_unlocked", {31'd0, locked}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
